dmem_store_unit: RTL and testbench

- Write-side counterpart of the data-memory read path: accepts scalar (32-bit) or vector (6 x 32-bit) store requests and serialises them into word writes on a single 32-bit memory write port.
- Sits between the execute/memory stage and the word-addressed data RAM.
- Lane k of the 192-bit store data goes to word address base+k, with lane 0 in bits [31:0].
- Reports completion and out-of-range stores.

---
 rtl/dmem_pkg.sv | 23 ++
 rtl/dmem_store_unit_if.sv | 27 ++
 rtl/dmem_store_unit.sv | 76 +++++++
 tb/tb_dmem_store_unit.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared constants, store-FSM state type and lane helper
// for the data-memory store path.
package dmem_pkg;

    localparam int S     = 32;
    localparam int V     = 192;
    localparam int SIZE  = 30000;
    localparam int LANES = V / S;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        DONE  = 2'd2
    } store_state_e;

    function automatic logic [S-1:0] get_lane(
        input logic [V-1:0] vec,
        input logic [2:0]   k
    );
        return vec[S*int'(k) +: S];
    endfunction

endpackage

// File: rtl/dmem_store_unit_if.sv
// Request handshake plus RAM write port of the store unit.
// master = requester/RAM side, slave = store unit.
interface dmem_store_unit_if;
    import dmem_pkg::*;

    logic         req_valid;
    logic         req_ready;
    logic         isVector;
    logic [S-1:0] address;
    logic [V-1:0] wd;
    logic         mem_we;
    logic [S-1:0] mem_addr;
    logic [S-1:0] mem_wd;
    logic         done;
    logic         oob;

    modport master (
        output req_valid, isVector, address, wd,
        input  req_ready, mem_we, mem_addr, mem_wd, done, oob
    );

    modport slave (
        input  req_valid, isVector, address, wd,
        output req_ready, mem_we, mem_addr, mem_wd, done, oob
    );

endinterface

// File: rtl/dmem_store_unit.sv
// Serialises scalar or 6-lane vector stores into single-word
// RAM writes, suppressing and flagging out-of-range lanes.
module dmem_store_unit
    import dmem_pkg::*;
(
    input logic              clk,
    input logic              rst,
    dmem_store_unit_if.slave bus
);

    store_state_e state;
    logic [2:0]   cnt;
    logic [2:0]   last;
    logic [S-1:0] base;
    logic [V-1:0] data;
    logic         sticky;
    logic [S-1:0] addr_q;
    logic [S-1:0] wd_q;

    logic [S:0]   idx;
    logic         in_range;
    logic [S-1:0] lane;

    // One extra bit so address wrap lands above SIZE.
    always_comb begin
        idx      = {1'b0, base} + {{(S-2){1'b0}}, cnt};
        in_range = idx < (S+1)'(SIZE);
        lane     = get_lane(data, cnt);
    end

    assign bus.req_ready = (state == IDLE);
    assign bus.mem_we    = (state == WRITE) && in_range;
    assign bus.mem_addr  = (state == WRITE) ? idx[S-1:0] : addr_q;
    assign bus.mem_wd    = (state == WRITE) ? lane : wd_q;
    assign bus.done      = (state == DONE);
    assign bus.oob       = (state == DONE) && sticky;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= 3'd0;
            last   <= 3'd0;
            base   <= '0;
            data   <= '0;
            sticky <= 1'b0;
            addr_q <= '0;
            wd_q   <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        base   <= bus.address;
                        data   <= bus.wd;
                        last   <= bus.isVector ? 3'(LANES-1) : 3'd0;
                        cnt    <= 3'd0;
                        sticky <= 1'b0;
                        state  <= WRITE;
                    end
                end
                WRITE: begin
                    addr_q <= idx[S-1:0];
                    wd_q   <= lane;
                    if (!in_range)
                        sticky <= 1'b1;
                    if (cnt == last)
                        state <= DONE;
                    else
                        cnt <= cnt + 3'd1;
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_store_unit.sv
// Self-checking bench for dmem_store_unit: vector table plus
// hand sequences, with a write/done scoreboard.
module tb_dmem_store_unit;
    import dmem_pkg::*;

    logic clk;
    logic rst;

    dmem_store_unit_if bus ();

    dmem_store_unit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] d;
    } wr_t;

    typedef struct {
        bit          vec;
        logic [31:0] addr;
        logic [191:0] wd;
        bit          oob;
    } vec_t;

    wr_t wq[$];
    bit  dq[$];
    int  n_checks = 0;
    int  n_fail   = 0;

    task automatic check(input string n, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", n, act, exp);
        end
    endtask

    function automatic bit in_r(input logic [31:0] a, input int i);
        logic [32:0] x;
        x = {1'b0, a} + 33'(i);
        return x < 33'(SIZE);
    endfunction

    task automatic push_exp(input bit vec, input logic [31:0] a,
                            input logic [191:0] d, input bit oob);
        int n;
        wr_t e;
        n = vec ? 6 : 1;
        for (int i = 0; i < n; i++) begin
            if (in_r(a, i)) begin
                e.a = a + 32'(i);
                e.d = d[32*i +: 32];
                wq.push_back(e);
            end
        end
        dq.push_back(oob);
    endtask

    // Scoreboard monitor: pops on every write and done pulse.
    always @(negedge clk) begin
        wr_t e;
        if (bus.mem_we === 1'b1) begin
            if (wq.size() == 0)
                check("unexpected_write", bus.mem_addr, 32'hxxxxxxxx);
            else begin
                e = wq.pop_front();
                check("write_addr", bus.mem_addr, e.a);
                check("write_data", bus.mem_wd, e.d);
            end
        end
        if (bus.done === 1'b1) begin
            if (dq.size() == 0)
                check("unexpected_done", 32'd1, 32'd0);
            else
                check("done_oob", 32'(bus.oob), 32'(dq.pop_front()));
        end
    end

    task automatic drive(input bit vec, input logic [31:0] a,
                         input logic [191:0] d);
        bus.req_valid = 1'b1;
        bus.isVector  = vec;
        bus.address   = a;
        bus.wd        = d;
    endtask

    task automatic do_store(input bit vec, input logic [31:0] a,
                            input logic [191:0] d, input bit oob);
        int n;
        int t;
        n = vec ? 6 : 1;
        push_exp(vec, a, d, oob);
        @(negedge clk);
        drive(vec, a, d);
        t = 0;
        while (bus.req_ready !== 1'b1 && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (t == 20) check("ready_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        bus.isVector  = ~vec;
        bus.address   = $urandom;
        bus.wd        = {6{$urandom}};
        for (int c = 1; c <= n + 2; c++) begin
            @(negedge clk);
            if (c <= n)
                check($sformatf("we_c%0d", c), 32'(bus.mem_we),
                      32'(in_r(a, c - 1)));
            else
                check($sformatf("we_c%0d", c), 32'(bus.mem_we), 32'd0);
            check($sformatf("done_c%0d", c), 32'(bus.done),
                  32'(c == n + 1));
            check($sformatf("ready_c%0d", c), 32'(bus.req_ready),
                  32'(c == n + 2));
        end
    endtask

    vec_t tbl[7];
    logic [191:0] l16;

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        l16 = {32'd6, 32'd5, 32'd4, 32'd3, 32'd2, 32'd1};
        tbl[0] = '{1'b0, 32'd100, {160'd0, 32'hDEADBEEF}, 1'b0};
        tbl[1] = '{1'b1, 32'd200, l16, 1'b0};
        tbl[2] = '{1'b1, 32'd29997,
                   {32'hA5, 32'hA4, 32'hA3, 32'hA2, 32'hA1, 32'hA0}, 1'b1};
        tbl[3] = '{1'b0, 32'd29999, {160'd0, 32'h12345678}, 1'b0};
        tbl[4] = '{1'b1, 32'hFFFFFFFE, l16, 1'b1};
        tbl[5] = '{1'b0, 32'd30000, {160'd0, 32'h0BADF00D}, 1'b1};
        tbl[6] = '{1'b1, 32'd29994,
                   {32'hF5, 32'hF4, 32'hF3, 32'hF2, 32'hF1, 32'hF0}, 1'b0};

        rst           = 1'b1;
        bus.req_valid = 1'b0;
        bus.isVector  = 1'b0;
        bus.address   = '0;
        bus.wd        = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_ready", 32'(bus.req_ready), 32'd1);
        check("rst_we", 32'(bus.mem_we), 32'd0);
        check("rst_addr", bus.mem_addr, 32'd0);
        check("rst_wd", bus.mem_wd, 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_oob", 32'(bus.oob), 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 7; i++)
            do_store(tbl[i].vec, tbl[i].addr, tbl[i].wd, tbl[i].oob);

        // Second request held during the first burst.
        push_exp(1'b1, 32'd300, l16, 1'b0);
        push_exp(1'b0, 32'd400, {160'd0, 32'hCAFEF00D}, 1'b0);
        @(negedge clk);
        drive(1'b1, 32'd300, l16);
        @(posedge clk);
        #1;
        drive(1'b0, 32'd400, {160'd0, 32'hCAFEF00D});
        for (int c = 1; c <= 11; c++) begin
            @(negedge clk);
            check($sformatf("b2b_we_c%0d", c), 32'(bus.mem_we),
                  32'(c <= 6 || c == 9));
            check($sformatf("b2b_done_c%0d", c), 32'(bus.done),
                  32'(c == 7 || c == 10));
            check($sformatf("b2b_ready_c%0d", c), 32'(bus.req_ready),
                  32'(c == 8 || c == 11));
            if (c == 9) bus.req_valid = 1'b0;
        end

        // Reset while lane 2 is being written.
        for (int i = 0; i < 3; i++) begin
            wr_t e;
            e.a = 32'd500 + 32'(i);
            e.d = l16[32*i +: 32];
            wq.push_back(e);
        end
        @(negedge clk);
        drive(1'b1, 32'd500, l16);
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            check($sformatf("rstb_we_c%0d", c), 32'(bus.mem_we), 32'd1);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rstb_ready", 32'(bus.req_ready), 32'd1);
        check("rstb_we", 32'(bus.mem_we), 32'd0);
        check("rstb_addr", bus.mem_addr, 32'd0);
        check("rstb_wd", bus.mem_wd, 32'd0);
        check("rstb_done", 32'(bus.done), 32'd0);
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            check("rstb_idle_we", 32'(bus.mem_we), 32'd0);
            check("rstb_idle_done", 32'(bus.done), 32'd0);
        end
        do_store(1'b0, 32'd7, {160'd0, 32'h55AA55AA}, 1'b0);

        check("queue_wr_drain", 32'(wq.size()), 32'd0);
        check("queue_done_drain", 32'(dq.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
